tli4970_spi_responder: RTL

SPI responder that emulates the TLI4970 current sensor on the motor board's sensor SPI bus. It runs in the 32 MHz domain, returns the 16-bit TLI4970 frame to any mode-0 SPI master, and snapshots the presented current or status word at chip-select assertion. It is used for hardware-in-the-loop and bench validation of the current readout path and control mode 3, with no physical sensor fitted.

---
 rtl/tli4970_spi_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tli4970_spi_responder.sv
// ----------------------------------------------------------------------------
// tli4970_spi_responder
//
// Emulates a TLI4970 current sensor as an SPI mode-0 responder (CPOL 0,
// CPHA 0) in the system clock domain. The 16-bit frame is snapshotted when
// chip select is asserted and shifted out MSB first. The master samples on
// SCK rising edges; MISO advances on SCK falling edges.
//
// Frame word:
//   value frame  : {1'b0, P, ocd_i, current_i[12:0]}
//   status frame : {1'b1, P, 1'b0,  status_i[12:0]}
//   P makes the 16-bit word carry an even number of ones.
//
// Optional feature macro: TLI4970_PARITY_EN
//   defined   -> bit 14 carries the even-parity bit P.
//   undefined -> bit 14 is always 0 and no parity logic is built.
//
// Parameters:
//   SYNC_STAGES    synchroniser depth on spi_sck_i / spi_ssel_i (>= 2)
//
// Ports:
//   CLK             in   system clock (32 MHz)
//   reset           in   synchronous active-high reset
//   spi_sck_i       in   SPI clock, asynchronous, idles low
//   spi_ssel_i      in   chip select, asynchronous, active low
//   spi_miso_o      out  serial data to the master, MSB first
//   spi_miso_oe     out  MISO output enable, high while a frame is selected
//   current_i       in   13-bit signed current value
//   ocd_i           in   over-current-detect flag (value frame)
//   status_valid_i  in   selects a status frame at snapshot time
//   status_i        in   13-bit status code (status frame)
//   frame_done_o    out  1-cycle pulse: frame ended after exactly 16 SCK rises
//   frame_abort_o   out  1-cycle pulse: frame ended with any other rise count
//   frame_count_o   out  number of completed frames, wraps at 0xFFFF
// ----------------------------------------------------------------------------
module tli4970_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        spi_sck_i,
  input  logic        spi_ssel_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe,
  input  logic [12:0] current_i,
  input  logic        ocd_i,
  input  logic        status_valid_i,
  input  logic [12:0] status_i,
  output logic        frame_done_o,
  output logic        frame_abort_o,
  output logic [15:0] frame_count_o
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  localparam logic [4:0] RISE_FULL = 5'd16;
  localparam logic [4:0] RISE_MAX  = 5'd31;

`ifdef TLI4970_PARITY_EN
  // Even parity over the 15 payload bits: P is set when they hold an odd
  // number of ones, so the full word always carries an even count.
  function automatic logic even_parity(input logic [14:0] payload);
    even_parity = ^payload;
  endfunction
`endif

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssel_sync;
  logic                   r_sck_d;
  logic                   r_ssel_d;

  logic                   w_sck;
  logic                   w_ssel;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_ssel_rise;
  logic                   w_ssel_fall;

  logic                   w_bit15;
  logic                   w_bit13;
  logic [12:0]            w_payload;
  logic                   w_par;
  logic [15:0]            w_word;

  state_t                 r_state;
  logic [15:0]            r_shift;
  logic [4:0]             r_rise_cnt;
  logic                   r_miso;
  logic                   r_miso_oe;
  logic                   r_done;
  logic                   r_abort;
  logic [15:0]            r_frame_cnt;

  // ---- synchroniser stage: SPI pins into the CLK domain ----
  // The ssel chain resets low so that WAIT_HIGH only leaves once a genuine
  // high level on the pin has propagated through, never on a reset artefact.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_ssel_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ssel_d    <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], spi_ssel_i};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_ssel_d    <= r_ssel_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_ssel      = r_ssel_sync[SYNC_STAGES-1];
  assign w_sck_rise  =  w_sck  & ~r_sck_d;
  assign w_sck_fall  = ~w_sck  &  r_sck_d;
  assign w_ssel_rise =  w_ssel & ~r_ssel_d;
  assign w_ssel_fall = ~w_ssel &  r_ssel_d;

  // ---- frame assembly: combinational word captured at snapshot ----
  assign w_bit15   = status_valid_i;
  assign w_bit13   = status_valid_i ? 1'b0 : ocd_i;
  assign w_payload = status_valid_i ? status_i : current_i;

`ifdef TLI4970_PARITY_EN
  assign w_par = even_parity({w_bit15, w_bit13, w_payload});
`else
  assign w_par = 1'b0;
`endif

  assign w_word = {w_bit15, w_par, w_bit13, w_payload};

  // ---- frame FSM: snapshot, shift-out and frame bookkeeping ----
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= WAIT_HIGH;
      r_shift     <= '0;
      r_rise_cnt  <= '0;
      r_miso      <= 1'b1;
      r_miso_oe   <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        WAIT_HIGH: begin
          r_miso    <= 1'b1;
          r_miso_oe <= 1'b0;
          if (w_ssel) begin
            r_state <= IDLE;
          end
        end

        IDLE: begin
          r_miso    <= 1'b1;
          r_miso_oe <= 1'b0;
          if (w_ssel_fall) begin
            r_shift    <= w_word;
            r_miso     <= w_word[15];
            r_miso_oe  <= 1'b1;
            r_rise_cnt <= '0;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          // End of frame wins over any SCK edge seen in the same cycle.
          if (w_ssel_rise) begin
            r_state   <= IDLE;
            r_miso    <= 1'b1;
            r_miso_oe <= 1'b0;
            if (r_rise_cnt == RISE_FULL) begin
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              r_abort <= 1'b1;
            end
          end else begin
            if (w_sck_rise && (r_rise_cnt != RISE_MAX)) begin
              r_rise_cnt <= r_rise_cnt + 5'd1;
            end
            // Zero fill means an overrunning master reads 0 after bit 0.
            if (w_sck_fall) begin
              r_shift <= {r_shift[14:0], 1'b0};
              r_miso  <= r_shift[14];
            end
          end
        end

        default: begin
          r_state   <= WAIT_HIGH;
          r_miso    <= 1'b1;
          r_miso_oe <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso_o    = r_miso;
  assign spi_miso_oe   = r_miso_oe;
  assign frame_done_o  = r_done;
  assign frame_abort_o = r_abort;
  assign frame_count_o = r_frame_cnt;

endmodule
